// File: rtl/data_stall_bridge_pkg.sv
// rtl/data_stall_bridge_pkg.sv - shared types and constants for the CPU data stall bridge
package data_stall_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } bridge_state_t;

  localparam logic [3:0]  BYTEENABLE_ALL       = 4'b1111;
  localparam logic [31:0] ERR_READDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/data_stall_bridge_wait_timer.sv
// rtl/data_stall_bridge_wait_timer.sv - saturating waitrequest cycle counter
module wait_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT    = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LIMIT_M1 = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Fires on the stalled cycle whose count brings the timer up to the limit.
  assign expired = count && (cnt_q >= LIMIT_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/data_stall_bridge.sv
// rtl/data_stall_bridge.sv - stalls the CPU data port across multi-cycle waitrequest bus accesses
module data_stall_bridge
  import data_stall_bridge_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_READDATA   = ERR_READDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_enable,
  output logic        cpu_clk_enable,
  input  logic [31:0] cpu_data_address,
  input  logic        cpu_data_read,
  input  logic        cpu_data_write,
  input  logic [31:0] cpu_data_writedata,
  output logic [31:0] cpu_data_readdata,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        bus_error
);

  bridge_state_t state_q, state_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic          read_q, read_d, write_q, write_d, err_q, err_d;
  logic          req, clk_en, timer_clear, timer_count, timer_expired;

  assign req = cpu_data_read | cpu_data_write;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    read_d      = read_q;
    write_d     = write_q;
    err_d       = err_q;
    clk_en      = 1'b0;
    timer_clear = 1'b0;
    timer_count = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_en = run_enable & ~req;
        if (req && run_enable) begin
          addr_d      = cpu_data_address & ~32'h3;
          wdata_d     = cpu_data_writedata;
          // A dual strobe is treated as a store.
          write_d     = cpu_data_write;
          read_d      = ~cpu_data_write;
          timer_clear = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (!avm_waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) begin
            rdata_d = avm_readdata;
          end
          state_d = DONE;
        end else begin
          timer_count = 1'b1;
          if (timer_expired) begin
            read_d  = 1'b0;
            write_d = 1'b0;
            err_d   = 1'b1;
            rdata_d = ERR_READDATA;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        clk_en = run_enable;
        if (run_enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .count  (timer_count),
    .expired(timer_expired)
  );

  assign cpu_clk_enable    = clk_en & ~reset;
  assign cpu_data_readdata = rdata_q;
  assign avm_address       = addr_q;
  assign avm_read          = read_q;
  assign avm_write         = write_q;
  assign avm_writedata     = wdata_q;
  assign avm_byteenable    = BYTEENABLE_ALL;
  assign bus_error         = err_q;

endmodule

// File: tb/tb_data_stall_bridge.sv
// tb/tb_data_stall_bridge.sv - self-checking bench for data_stall_bridge
module tb_data_stall_bridge;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_enable = 1'b1;
  logic        cpu_clk_enable;
  logic [31:0] cpu_data_address = '0;
  logic        cpu_data_read = 1'b0;
  logic        cpu_data_write = 1'b0;
  logic [31:0] cpu_data_writedata = '0;
  logic [31:0] cpu_data_readdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        bus_error;

  data_stall_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk               (clk),
    .reset             (reset),
    .run_enable        (run_enable),
    .cpu_clk_enable    (cpu_clk_enable),
    .cpu_data_address  (cpu_data_address),
    .cpu_data_read     (cpu_data_read),
    .cpu_data_write    (cpu_data_write),
    .cpu_data_writedata(cpu_data_writedata),
    .cpu_data_readdata (cpu_data_readdata),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .bus_error         (bus_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory device and the bench's own model of what it should hold.
  logic [31:0] mem       [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [31:0] model_get(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  int          cur_wait = 0;
  int          acc_cycles = 0;
  int          strobe_cycles = 0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        exp_wr = 1'b0;
  logic        chk_bus = 1'b0;

  always @(negedge clk) begin
    if (avm_read || avm_write) begin
      avm_waitrequest = (acc_cycles < cur_wait);
      avm_readdata    = mem_get(avm_address);
      if (chk_bus) begin
        chk("avm_address", avm_address, exp_addr);
        chk("avm_write", {31'b0, avm_write}, {31'b0, exp_wr});
        chk("avm_read", {31'b0, avm_read}, {31'b0, ~exp_wr});
        chk("avm_byteenable", {28'b0, avm_byteenable}, 32'hF);
        if (exp_wr) chk("avm_writedata", avm_writedata, exp_data);
      end
      if (!avm_waitrequest && avm_write) mem[avm_address] = avm_writedata;
      acc_cycles++;
      strobe_cycles++;
    end else begin
      acc_cycles = 0;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    int          waitn;
    int          hold;
    int          exp_stalls;
    int          exp_acc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // Called at posedge+1; returns at posedge+1 of the first IDLE cycle after retirement.
  task automatic run_vec(input vec_t v, input string tag);
    int stalls;
    int guard;
    cur_wait = v.waitn;
    exp_addr = v.addr & ~32'h3;
    exp_wr   = v.wr;
    exp_data = v.wdata;
    strobe_cycles = 0;
    chk_bus  = 1'b1;
    cpu_data_address   = v.addr;
    cpu_data_read      = v.rd;
    cpu_data_write     = v.wr;
    cpu_data_writedata = v.wdata;
    #1;
    stalls = 0;
    guard  = 0;
    while (!cpu_clk_enable && guard < 200) begin
      stalls++;
      guard++;
      @(posedge clk);
      #2;
    end
    chk({tag, "_stalls"}, stalls, v.exp_stalls);
    chk({tag, "_bus_cycles"}, strobe_cycles, v.exp_acc);
    chk({tag, "_rdata"}, cpu_data_readdata, v.exp_rdata);
    chk({tag, "_bus_error"}, {31'b0, bus_error}, {31'b0, v.exp_err});
    chk({tag, "_strobes_dropped"}, {30'b0, avm_read, avm_write}, 32'h0);
    for (int i = 0; i < v.hold; i++) begin
      run_enable = 1'b0;
      #1;
      chk({tag, "_hold_clk_en"}, {31'b0, cpu_clk_enable}, 32'h0);
      @(posedge clk);
      #2;
      chk({tag, "_hold_rdata"}, cpu_data_readdata, v.exp_rdata);
    end
    run_enable = 1'b1;
    #1;
    if (v.hold > 0) chk({tag, "_release_clk_en"}, {31'b0, cpu_clk_enable}, 32'h1);
    @(posedge clk);
    #1;
    cpu_data_read  = 1'b0;
    cpu_data_write = 1'b0;
    chk_bus        = 1'b0;
  endtask

  vec_t        tbl[7];
  vec_t        v;
  logic [31:0] m_rreg;
  logic        m_err;
  int          op;
  int          w;
  logic [31:0] a;

  initial begin
    mem[32'h10]       = 32'h1234_5678;
    model_mem[32'h10] = 32'h1234_5678;
    mem[32'h40]       = 32'h0BAD_F00D;
    model_mem[32'h40] = 32'h0BAD_F00D;

    tbl[0] = '{32'h10, 1'b1, 1'b0, 32'h0,         0,   0, 2, 1, 32'h1234_5678, 1'b0};
    tbl[1] = '{32'h20, 1'b0, 1'b1, 32'hCAFE_F00D, 3,   0, 5, 4, 32'h1234_5678, 1'b0};
    tbl[2] = '{32'h20, 1'b1, 1'b0, 32'h0,         1,   0, 3, 2, 32'hCAFE_F00D, 1'b0};
    tbl[3] = '{32'h13, 1'b1, 1'b1, 32'h5555_AAAA, 0,   0, 2, 1, 32'hCAFE_F00D, 1'b0};
    tbl[4] = '{32'h10, 1'b1, 1'b0, 32'h0,         0,   3, 2, 1, 32'h5555_AAAA, 1'b0};
    tbl[5] = '{32'h40, 1'b1, 1'b0, 32'h0,         7,   0, 9, 8, 32'h0BAD_F00D, 1'b0};
    tbl[6] = '{32'h44, 1'b1, 1'b0, 32'h0,         100, 1, 9, 8, 32'hDEAD_BEEF, 1'b1};

    #3;
    chk("reset_clk_en", {31'b0, cpu_clk_enable}, 32'h0);
    chk("reset_strobes", {30'b0, avm_read, avm_write}, 32'h0);
    chk("reset_address", avm_address, 32'h0);
    chk("reset_writedata", avm_writedata, 32'h0);
    chk("reset_rdata", cpu_data_readdata, 32'h0);
    chk("reset_bus_error", {31'b0, bus_error}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    chk("mem_0x20", mem_get(32'h20), 32'hCAFE_F00D);
    chk("mem_0x10", mem_get(32'h10), 32'h5555_AAAA);

    // Reset while a read is stalled on the bus.
    cur_wait = 1000;
    cpu_data_address = 32'h80;
    cpu_data_read    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("rst_pre_avm_read", {31'b0, avm_read}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_avm_read", {31'b0, avm_read}, 32'h0);
    chk("rst_clk_en", {31'b0, cpu_clk_enable}, 32'h0);
    chk("rst_bus_error", {31'b0, bus_error}, 32'h0);
    chk("rst_rdata", cpu_data_readdata, 32'h0);
    cpu_data_read = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_idle_clk_en", {31'b0, cpu_clk_enable}, 32'h1);
    @(posedge clk);
    #1;

    // No access is issued while run_enable is low in IDLE.
    run_enable       = 1'b0;
    cpu_data_address = 32'h104;
    cpu_data_read    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("gated_no_read", {31'b0, avm_read}, 32'h0);
    chk("gated_clk_en", {31'b0, cpu_clk_enable}, 32'h0);
    cpu_data_read = 1'b0;
    run_enable    = 1'b1;
    @(posedge clk);
    #1;

    m_rreg = 32'h0;
    m_err  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 2);
      w  = ($urandom_range(0, 5) == 0) ? $urandom_range(T, T + 2) : $urandom_range(0, 4);
      a  = 32'h100 + $urandom_range(0, 63);
      v.addr  = a;
      v.rd    = (op != 1);
      v.wr    = (op != 0);
      v.wdata = $urandom;
      v.waitn = w;
      v.hold  = $urandom_range(0, 2);
      if (w >= T) begin
        m_rreg = 32'hDEAD_BEEF;
        m_err  = 1'b1;
        v.exp_acc = T;
      end else begin
        v.exp_acc = w + 1;
        if (v.wr) model_mem[a & ~32'h3] = v.wdata;
        else      m_rreg = model_get(a & ~32'h3);
      end
      v.exp_stalls = 1 + v.exp_acc;
      v.exp_rdata  = m_rreg;
      v.exp_err    = m_err;
      run_vec(v, $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      a = 32'h100 + 32'(i * 4);
      chk($sformatf("rnd_mem_%h", a), mem_get(a), model_get(a));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_stall_bridge.md
# data_stall_bridge

Sits between the `mips_cpu_harvard` data port and a wait-state memory with an Avalon-style `waitrequest` handshake. It turns the CPU's single-cycle data accesses into multi-cycle bus transactions and holds the CPU by driving its `clk_enable` low until each access completes. Bus timeouts are flagged as errors. The testbench's run enable passes through it, so the bridge is the only driver of `cpu_clk_enable`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum number of `waitrequest`-high cycles tolerated per access.
- `ERR_READDATA`, default 32'hDEAD_BEEF: value returned to the CPU on a timed-out read.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `run_enable`  in  1  global run gate from the testbench.
- `cpu_clk_enable`  out  1  clock enable to the CPU.
- `cpu_data_address`  in  32  CPU data address.
- `cpu_data_read`  in  1  CPU read strobe.
- `cpu_data_write`  in  1  CPU write strobe.
- `cpu_data_writedata`  in  32  CPU store data.
- `cpu_data_readdata`  out  32  load data returned to the CPU.
- `avm_address`  out  32  word-aligned bus address.
- `avm_read`  out  1  bus read request.
- `avm_write`  out  1  bus write request.
- `avm_writedata`  out  32  bus store data.
- `avm_byteenable`  out  4  byte enables; constant 4'b1111.
- `avm_waitrequest`  in  1  memory stall.
- `avm_readdata`  in  32  memory read data.
- `bus_error`  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- `req` = `cpu_data_read | cpu_data_write`.
- If both strobes are high, the access is performed as a write.
- IDLE:
  - `cpu_clk_enable = run_enable & ~req`. This is combinational, so the CPU is frozen in the same cycle the request appears.
  - On `req & run_enable`: latch `{cpu_data_address[31:2],2'b00}`, the write data and the direction; assert registered `avm_read` or `avm_write`; clear the wait timer; go to ACCESS.
- ACCESS:
  - `cpu_clk_enable = 0`.
  - The avm outputs are held stable while `avm_waitrequest` is high.
  - At the edge where `avm_waitrequest == 0`: drop `avm_read`/`avm_write`; capture `avm_readdata` into the read register (reads only); go to DONE.
  - If the timer reaches `TIMEOUT_CYCLES` with `waitrequest` still high: drop the strobes; set `bus_error`; load `ERR_READDATA` into the read register; go to DONE.
- DONE:
  - `cpu_clk_enable = run_enable`.
  - `cpu_data_readdata` = read register.
  - On an edge with `run_enable` high (the CPU retires the instruction), go to IDLE.
- `cpu_data_readdata` always shows the read register, which holds its value outside DONE.
- `bus_error` is cleared only by reset.

## Timing
- Reset (asynchronous) values:
  - State goes to IDLE.
  - `avm_read`, `avm_write`, `avm_address`, `avm_writedata`, read register and `bus_error` are all 0.
  - `cpu_clk_enable` is forced to 0 while `reset` is high.
- Reset during ACCESS drops the bus strobes immediately. The transaction is abandoned and no completion is reported.
- Latency with zero wait states: request in cycle N (IDLE), ACCESS in cycle N+1, DONE in cycle N+2, CPU advances at the end of N+2. That is 2 stall cycles.
- Each `waitrequest`-high cycle adds 1 stall cycle.
- A timeout completes after `TIMEOUT_CYCLES` ACCESS cycles plus the DONE cycle.
- `run_enable` low in IDLE: no access is issued.
- `run_enable` low in ACCESS: the bus access still completes.
- `run_enable` low in DONE: the bridge stays in DONE and the read data stays stable.
- Back-to-back accesses: a new request is accepted on the IDLE cycle that immediately follows DONE.
- The timer saturates; it never wraps.

## Structure
- `data_stall_bridge_pkg` holds:
  - the `bridge_state_t` enum (IDLE/ACCESS/DONE)
  - `BYTEENABLE_ALL = 4'b1111`
  - the default `ERR_READDATA` constant
- One sub-module, `wait_timer`: a saturating counter of `$clog2(TIMEOUT_CYCLES+1)` bits with `clear`/`count` inputs and an `expired` output.

## Test plan
- Zero-wait read: CPU reads 0x0000_0010 and memory returns 0x1234_5678 with `waitrequest=0` -> `cpu_clk_enable` is low for exactly 2 cycles, then `cpu_data_readdata = 0x1234_5678`.
- Wait-state write: write 0xCAFE_F00D to 0x0000_0020 with `waitrequest` high for 3 cycles -> `avm_write`/address/data are stable for 4 cycles, the CPU stalls 5 cycles, and memory holds 0xCAFE_F00D.
- Timeout: `waitrequest` stuck high with `TIMEOUT_CYCLES=8` -> after 8 ACCESS cycles the strobes drop, `bus_error=1` and the read data is 0xDEAD_BEEF.
- Misaligned and dual strobe: address 0x0000_0013 with read and write both high -> `avm_address = 0x0000_0010`, `avm_write=1`, `avm_read=0`.
- Reset mid-access: assert `reset` during ACCESS -> `avm_read` goes to 0 in the same cycle without a clock edge, the state is IDLE, `bus_error=0`.
- `run_enable` gating: `run_enable=0` while in DONE for 3 cycles -> the state stays DONE and the read data is held; the CPU advances on the first edge with `run_enable=1`.
